// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
//
// Receive-side VGA timing recovery. Consumes hsync/vsync/rgb on the pixel
// clock, rebuilds the horizontal (hc) and vertical (vc) position counters from
// the sync edges, checks line/frame timing and only reports valid pixels once
// LOCK_FRAMES consecutive clean frames have been seen.
//
// Every registered output reflects the inputs sampled one cycle earlier.
//
// Ports:
//   clk         in   pixel clock; all inputs synchronous to it
//   reset       in   asynchronous, active-low; clears all state
//   hsync       in   horizontal sync (polarity set by SYNC_NEG)
//   vsync       in   vertical sync   (polarity set by SYNC_NEG)
//   rgb_in      in   12-bit pixel data
//   x, y        out  recovered column/row, 0 when de=0
//   de          out  pixel valid (active region AND locked)
//   rgb_out     out  rgb_in aligned with x/y/de, 0 when de=0
//   frame_start out  one-cycle pulse with de at x=0, y=0
//   locked      out  timing lock status
//   err         out  one-cycle pulse per cycle with any timing violation
//   err_count   out  saturating count of err pulses
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_NEG    = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        de,
  output logic [11:0] rgb_out,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {S_UNLOCKED, S_TRAIN, S_LOCKED} state_t;

  localparam int GW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0] HX0     = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HX1     = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] VY0     = 10'(V_SYNC + V_BP - 1);
  localparam logic [9:0] VY1     = 10'(V_SYNC + V_BP - 1 + V_ACTIVE);
  localparam logic [9:0] HT_W    = 10'(H_TOTAL);
  localparam logic [9:0] VT_W    = 10'(V_TOTAL);
  localparam logic [9:0] HS_W    = 10'(H_SYNC);
  localparam logic [9:0] CNT_MAX = '1;
  localparam logic       SYNC_POL = (SYNC_NEG != 0);
  localparam logic [GW-1:0] GF_LAST = GW'(LOCK_FRAMES - 1);

  logic          hs_a, vs_a, hs_d, vs_d;
  logic          hs_rise, hs_fall, vs_rise, consume;
  logic [9:0]    hc_q, vc_q, hc, vc;
  logic          vpend_q, line_ok_q, frame_ok_q;
  logic          line_bad, width_bad, frame_bad, h_timeout, v_timeout;
  logic          err_now, unlock, active, de_n;
  state_t        state_q, state_n;
  logic [GW-1:0] gf_q, gf_n;

  // Normalise both syncs to active-high, then detect edges against the
  // previous sample.
  assign hs_a    = hsync ^ SYNC_POL;
  assign vs_a    = vsync ^ SYNC_POL;
  assign hs_rise = hs_a & ~hs_d;
  assign hs_fall = ~hs_a & hs_d;
  assign vs_rise = vs_a & ~vs_d;

  // A vsync edge in the same cycle as the hsync edge is consumed immediately.
  assign consume = hs_rise & (vpend_q | vs_rise);

  // hc/vc are the position of the pixel on the inputs this cycle; hc_q/vc_q
  // hold the previous cycle's position.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned and infers a latch.
    hc = (hc_q == CNT_MAX) ? hc_q : hc_q + 10'd1;
    vc = vc_q;
    if (hs_rise) begin
      hc = '0;
      if (consume)              vc = '0;
      else if (vc_q != CNT_MAX) vc = vc_q + 10'd1;
    end
  end

  // The hsync pulse started at hc=0, so at deassertion hc equals its width.
  assign line_bad  = hs_rise & line_ok_q & (hc_q + 10'd1 != HT_W);
  assign width_bad = hs_fall & (hc != HS_W);
  assign frame_bad = consume & frame_ok_q & (vc_q + 10'd1 != VT_W);
  // Counters only pass these values once between edges, so each timeout
  // fires a single time and is re-armed by the next edge.
  assign h_timeout = (hc == HT_W);
  assign v_timeout = hs_rise & (vc == VT_W);
  assign err_now   = line_bad | width_bad | frame_bad | h_timeout | v_timeout;
  assign unlock    = err_now & (state_q != S_UNLOCKED);

  always_comb begin
    state_n = state_q;
    gf_n    = gf_q;
    unique case (state_q)
      S_UNLOCKED: begin
        if (consume) begin
          state_n = S_TRAIN;
          gf_n    = '0;
        end
      end
      S_TRAIN: begin
        if (err_now) begin
          state_n = S_UNLOCKED;
        end else if (consume) begin
          gf_n = gf_q + GW'(1);
          if (gf_q == GF_LAST) state_n = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (err_now) state_n = S_UNLOCKED;
      end
      default: state_n = S_UNLOCKED;
    endcase
  end

  // A violating cycle never produces a pixel: lock is dropped from here on.
  assign active = (hc >= HX0) && (hc < HX1) && (vc >= VY0) && (vc < VY1);
  assign de_n   = active & (state_q == S_LOCKED) & ~err_now;
  assign locked = (state_q == S_LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      hc_q        <= '0;
      vc_q        <= '0;
      vpend_q     <= 1'b0;
      line_ok_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      state_q     <= S_UNLOCKED;
      gf_q        <= '0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      err_count   <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values regardless of statement order.
      hs_d    <= hs_a;
      vs_d    <= vs_a;
      hc_q    <= hc;
      vc_q    <= vc;
      vpend_q <= consume ? 1'b0 : (vs_rise | vpend_q);

      // The first line/frame after reset or unlock has no valid reference.
      line_ok_q  <= unlock ? 1'b0 : (hs_rise | line_ok_q);
      frame_ok_q <= unlock ? 1'b0 : (consume | frame_ok_q);

      state_q <= state_n;
      gf_q    <= gf_n;

      x           <= de_n ? hc - HX0 : '0;
      y           <= de_n ? vc - VY0 : '0;
      de          <= de_n;
      rgb_out     <= de_n ? rgb_in : '0;
      frame_start <= de_n & (hc == HX0) & (vc == VY0);

      err <= err_now;
      if (err_now && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Drives a reduced-geometry VGA stream (same rules, small numbers) into two
// decoders, one built for active-low syncs and one for active-high syncs, and
// compares every output each cycle against a behavioural model that tracks
// "cycles since line start" / "lines since frame start" as plain integers.
// Directed steps cover lock-up, short lines, narrow hsync, missing syncs,
// mid-line reset and error-count saturation.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HA = 16, HS = 4, HB = 3, HT = 28;
  localparam int VA = 8,  VS = 2, VB = 3, VT = 16;
  localparam int LF = 2;
  localparam int X0 = HS + HB;
  localparam int Y0 = VS + VB - 1;
  localparam int MODE_UNL = 0, MODE_TRN = 1, MODE_LCK = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hs_lvl = 1'b0, vs_lvl = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        hsync_n, vsync_n;

  logic [9:0]  x_n, y_n, x_p, y_p;
  logic        de_n, de_p, fs_n, fs_p, lk_n, lk_p, er_n, er_p;
  logic [11:0] rgb_n, rgb_p;
  logic [7:0]  ec_n, ec_p;

  assign hsync_n = ~hs_lvl;
  assign vsync_n = ~vs_lvl;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .SYNC_NEG(1), .LOCK_FRAMES(LF)
  ) dut_n (
    .clk(clk), .reset(reset), .hsync(hsync_n), .vsync(vsync_n),
    .rgb_in(rgb_in), .x(x_n), .y(y_n), .de(de_n), .rgb_out(rgb_n),
    .frame_start(fs_n), .locked(lk_n), .err(er_n), .err_count(ec_n)
  );

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .SYNC_NEG(0), .LOCK_FRAMES(LF)
  ) dut_p (
    .clk(clk), .reset(reset), .hsync(hs_lvl), .vsync(vs_lvl),
    .rgb_in(rgb_in), .x(x_p), .y(y_p), .de(de_p), .rgb_out(rgb_p),
    .frame_start(fs_p), .locked(lk_p), .err(er_p), .err_count(ec_p)
  );

  int n_cmp = 0, n_bad = 0;
  bit in_reset = 1'b1;

  // Reference model state.
  int m_hs, m_vs, m_col, m_row, m_pend, m_line_seen, m_frame_seen;
  int m_mode, m_good, m_ecount;
  // Expected outputs after the next clock edge.
  int e_x, e_y, e_de, e_rgb, e_fs, e_locked, e_err, e_ecnt;

  // Observations gathered by the bench during directed steps.
  int de_cnt, fs_cnt, err_cnt, corner_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hs = 0; m_vs = 0; m_col = 0; m_row = 0; m_pend = 0;
    m_line_seen = 0; m_frame_seen = 0; m_mode = MODE_UNL; m_good = 0; m_ecount = 0;
    e_x = 0; e_y = 0; e_de = 0; e_rgb = 0; e_fs = 0; e_locked = 0; e_err = 0; e_ecnt = 0;
  endtask

  // One pixel clock of the stream, with syncs as active-high levels.
  task automatic model_cycle(input bit hs, input bit vs, input logic [11:0] rgb);
    bit rise, fall, vrise, cons, bad, act;
    int ncol, nrow;
    rise  = hs && !m_hs;
    fall  = !hs && m_hs;
    vrise = vs && !m_vs;
    ncol  = rise ? 0 : ((m_col < 1023) ? m_col + 1 : 1023);
    cons  = rise && (m_pend != 0 || vrise);
    nrow  = m_row;
    if (rise) nrow = cons ? 0 : ((m_row < 1023) ? m_row + 1 : 1023);

    bad = (rise && m_line_seen != 0 && (m_col + 1 != HT)) ||
          (fall && ncol != HS) ||
          (cons && m_frame_seen != 0 && (m_row + 1 != VT)) ||
          (ncol == HT) ||
          (rise && nrow == VT);

    act = (m_mode == MODE_LCK) && !bad &&
          ncol >= X0 && ncol < X0 + HA && nrow >= Y0 && nrow < Y0 + VA;

    e_de  = act;
    e_x   = act ? ncol - X0 : 0;
    e_y   = act ? nrow - Y0 : 0;
    e_rgb = act ? int'(rgb) : 0;
    e_fs  = act && ncol == X0 && nrow == Y0;
    e_err = bad;
    if (bad && m_ecount < 255) m_ecount++;
    e_ecnt = m_ecount;

    if (bad && m_mode != MODE_UNL) begin
      m_mode = MODE_UNL;
      m_line_seen = 0;
      m_frame_seen = 0;
    end else begin
      if (rise) m_line_seen = 1;
      if (cons) begin
        m_frame_seen = 1;
        case (m_mode)
          MODE_UNL: begin m_mode = MODE_TRN; m_good = 0; end
          MODE_TRN: begin m_good++; if (m_good == LF) m_mode = MODE_LCK; end
          default: ;
        endcase
      end
    end

    m_pend   = cons ? 0 : (vrise ? 1 : m_pend);
    m_col    = ncol;
    m_row    = nrow;
    m_hs     = hs;
    m_vs     = vs;
    e_locked = (m_mode == MODE_LCK);
  endtask

  task automatic compare_all(input string p);
    check({p, ".x"},           p == "n" ? x_n   : x_p,   e_x);
    check({p, ".y"},           p == "n" ? y_n   : y_p,   e_y);
    check({p, ".de"},          p == "n" ? de_n  : de_p,  e_de);
    check({p, ".rgb_out"},     p == "n" ? rgb_n : rgb_p, e_rgb);
    check({p, ".frame_start"}, p == "n" ? fs_n  : fs_p,  e_fs);
    check({p, ".locked"},      p == "n" ? lk_n  : lk_p,  e_locked);
    check({p, ".err"},         p == "n" ? er_n  : er_p,  e_err);
    check({p, ".err_count"},   p == "n" ? ec_n  : ec_p,  e_ecnt);
  endtask

  task automatic step(input bit hs, input bit vs, input logic [11:0] rgb);
    hs_lvl = hs;
    vs_lvl = vs;
    rgb_in = rgb;
    if (in_reset) model_reset();
    else          model_cycle(hs, vs, rgb);
    @(posedge clk);
    #1;
    compare_all("n");
    compare_all("p");
    if (de_n) de_cnt++;
    if (fs_n) fs_cnt++;
    if (er_n) err_cnt++;
    if (de_n && (x_n == 0 || x_n == HA - 1) && (y_n == 0 || y_n == VA - 1)) corner_cnt++;
  endtask

  task automatic gen_line(input int r, input int len, input int hw, input bit vs_on);
    for (int c = 0; c < len; c++) begin
      logic [11:0] px;
      int xx, yy;
      xx = c - X0;
      yy = r - Y0;
      if (c >= X0 && c < X0 + HA && r >= Y0 && r < Y0 + VA) px = {xx[3:0], yy[3:0], 4'h5};
      else                                                  px = 12'($urandom);
      step(c < hw, vs_on && r < VS, px);
    end
  endtask

  task automatic gen_rows(input int r0, input int r1, input bit vs_on, input int short_row, input int narrow_row);
    for (int r = r0; r <= r1; r++)
      gen_line(r, (r == short_row) ? HT - 1 : HT, (r == narrow_row) ? HS - 1 : HS, vs_on);
  endtask

  task automatic gen_frame(input bit vs_on, input int short_row, input int narrow_row);
    gen_rows(0, VT - 1, vs_on, short_row, narrow_row);
  endtask

  task automatic clear_obs();
    de_cnt = 0; fs_cnt = 0; err_cnt = 0; corner_cnt = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'($urandom));
  endtask

  initial begin
    int r;
    model_reset();

    // Reset held: everything reads zero.
    in_reset = 1'b1;
    idle(3);
    reset = 1'b1;
    in_reset = 1'b0;
    idle(5);

    // Nominal stream: lock after the second full frame that follows vsync.
    clear_obs();
    gen_frame(1'b1, -1, -1);
    gen_frame(1'b1, -1, -1);
    check("locked before 3rd frame", lk_n, 0);
    clear_obs();
    gen_frame(1'b1, -1, -1);
    check("locked in 3rd frame", lk_n, 1);
    check("de count 3rd frame", de_cnt, HA * VA);
    check("frame_start count", fs_cnt, 1);
    check("corner pixels", corner_cnt, 4);
    check("err_count nominal", ec_n, 0);

    // One line shortened by a clock.
    r = $urandom_range(1, VT - 2);
    clear_obs();
    gen_frame(1'b1, r, -1);
    check("short line err pulses", err_cnt, 1);
    check("short line err_count", ec_n, 1);
    gen_frame(1'b1, -1, -1);
    gen_frame(1'b1, -1, -1);
    check("not relocked yet", lk_n, 0);
    clear_obs();
    gen_frame(1'b1, -1, -1);
    check("relocked after short line", lk_n, 1);
    check("de count after relock", de_cnt, HA * VA);

    // Hsync pulse one clock narrow.
    r = $urandom_range(0, VT - 1);
    clear_obs();
    gen_frame(1'b1, -1, r);
    check("narrow hsync err pulses", err_cnt, 1);
    check("narrow hsync err_count", ec_n, 2);
    gen_frame(1'b1, -1, -1);
    gen_frame(1'b1, -1, -1);
    gen_frame(1'b1, -1, -1);
    check("relocked after narrow hsync", lk_n, 1);

    // Hsync stops mid-line for more than a line time.
    clear_obs();
    gen_rows(0, 5, 1'b1, -1, -1);
    gen_line(6, HT / 2, HS, 1'b1);
    idle(2 * HT);
    check("hsync timeout err pulses", err_cnt, 1);
    check("hsync timeout err_count", ec_n, 3);
    gen_frame(1'b1, -1, -1);
    gen_frame(1'b1, -1, -1);
    gen_frame(1'b1, -1, -1);
    check("relocked after hsync loss", lk_n, 1);

    // A frame without vsync.
    clear_obs();
    gen_frame(1'b0, -1, -1);
    check("vsync timeout err pulses", err_cnt, 1);
    check("vsync timeout err_count", ec_n, 4);
    gen_frame(1'b1, -1, -1);
    gen_frame(1'b1, -1, -1);
    gen_frame(1'b1, -1, -1);
    check("relocked after vsync loss", lk_n, 1);

    // Asynchronous reset in the middle of an active line.
    gen_rows(0, Y0 + 2, 1'b1, -1, -1);
    gen_line(Y0 + 3, X0 + 5, HS, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("n");
    compare_all("p");
    in_reset = 1'b1;
    idle(3);
    reset = 1'b1;
    in_reset = 1'b0;
    clear_obs();
    idle(HT - (X0 + 5) - 3);
    gen_rows(Y0 + 4, VT - 1, 1'b1, -1, -1);
    gen_frame(1'b1, -1, -1);
    gen_frame(1'b1, -1, -1);
    check("no de before relock", de_cnt, 0);
    check("err_count after reset", ec_n, 0);
    clear_obs();
    gen_frame(1'b1, -1, -1);
    check("relocked after reset", lk_n, 1);
    check("de count after reset relock", de_cnt, HA * VA);

    // 300 short lines with no vsync: the error count saturates.
    for (int i = 0; i < 300; i++) gen_line(VT, HT - 1, HS, 1'b0);
    check("err_count saturated n", ec_n, 255);
    check("err_count saturated p", ec_p, 255);
    check("unlocked after bad lines", lk_n, 0);
    gen_frame(1'b1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
